// File: rtl/fibonacci_pkg.sv
// rtl/fibonacci_pkg.sv - shared types and widths for the Fibonacci calculator
package fibonacci_pkg;

  localparam int TERM_W = 3;
  localparam int RES_W  = 8;

  typedef struct packed {
    logic             valid;
    logic [RES_W-1:0] result;
  } t_output_interface;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } t_fib_state;

endpackage

// File: rtl/fibonacci_st.sv
// rtl/fibonacci_st.sv - sequential Fibonacci calculator (optional busy output via FIBONACCI_BUSY_EN)
module fibonacci_st
  import fibonacci_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TERM_W-1:0] term,
  output t_output_interface output_interface
`ifdef FIBONACCI_BUSY_EN
  ,
  output logic              busy
`endif
);

  t_fib_state        state;
  t_fib_state        next_state;
  logic [TERM_W-1:0] term_q;
  logic [TERM_W-1:0] cnt;
  logic [RES_W-1:0]  a;
  logic [RES_W-1:0]  b;
  t_output_interface out_q;

  assign output_interface = out_q;

  // State register; reset returns to IDLE immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an unused encoding falls back to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt == term_q) next_state = DONE;
      DONE:    if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: a/b walk the sequence until cnt reaches the latched index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      term_q       <= '0;
      cnt          <= '0;
      a            <= '0;
      b            <= RES_W'(1);
      out_q.valid  <= 1'b0;
      out_q.result <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_q.valid <= 1'b0;
          if (start) begin
            term_q <= term;
            a      <= '0;
            b      <= RES_W'(1);
            cnt    <= '0;
          end
        end
        CALC: begin
          if (cnt == term_q) begin
            out_q.result <= a;
            out_q.valid  <= 1'b1;
          end else begin
            a   <= b;
            b   <= a + b;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!start) out_q.valid <= 1'b0;
        end
        default: begin
          out_q.valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIBONACCI_BUSY_EN
  // Registered busy flag that tracks residence in CALC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (next_state == CALC);
    end
  end
`endif

endmodule

// File: tb/tb_fibonacci_st.sv
// tb/tb_fibonacci_st.sv - self-checking bench for fibonacci_st
module tb_fibonacci_st;
  import fibonacci_pkg::*;

  logic              clk;
  logic              rst;
  logic              start;
  logic [TERM_W-1:0] term;
  t_output_interface oi;
`ifdef FIBONACCI_BUSY_EN
  logic              busy;
`endif

  int total;
  int bad;
  int last_result;

  fibonacci_st dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .term             (term),
    .output_interface (oi)
`ifdef FIBONACCI_BUSY_EN
    ,
    .busy             (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fib_ref(input int n);
    int seq[$];
    seq = {0, 1};
    while (seq.size() <= n) seq.push_back(seq[seq.size()-1] + seq[seq.size()-2]);
    return seq[n];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int alt, input int hold, input bit drop_early);
    int lat;
    term  = n[2:0];
    start = 1'b1;
    step();
    if (alt >= 0) term = alt[2:0];
    if (drop_early) start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (oi.valid === 1'b1) begin
        lat = k;
        break;
      end
      check("calc_result_held", 32'(oi.result), 32'(last_result));
`ifdef FIBONACCI_BUSY_EN
      check("busy_in_calc", 32'(busy), 32'd1);
`endif
    end
    check("latency", 32'(lat), 32'(n + 1));
    check("result", 32'(oi.result), 32'(fib_ref(n)));
`ifdef FIBONACCI_BUSY_EN
    check("busy_after_calc", 32'(busy), 32'd0);
`endif
    last_result = fib_ref(n);
    if (!drop_early) begin
      for (int h = 0; h < hold; h++) begin
        step();
        check("held_valid", 32'(oi.valid), 32'd1);
        check("held_result", 32'(oi.result), 32'(last_result));
      end
      start = 1'b0;
    end
    step();
    check("valid_drop", 32'(oi.valid), 32'd0);
    check("idle_result_kept", 32'(oi.result), 32'(last_result));
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    last_result = 0;
    rst         = 1'b0;
    start       = 1'b0;
    term        = '0;

    // reset held while start toggles
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      term  = TERM_W'($urandom_range(0, 7));
      step();
      check("reset_valid", 32'(oi.valid), 32'd0);
      check("reset_result", 32'(oi.result), 32'd0);
`ifdef FIBONACCI_BUSY_EN
      check("reset_busy", 32'(busy), 32'd0);
`endif
    end
    start = 1'b0;
    #2 rst = 1'b1;
    step();

    // term 7 held, then 0 and 1
    run(7, -1, 3, 1'b0);
    run(0, -1, 1, 1'b0);
    run(1, -1, 1, 1'b0);

    // sweep of all indices
    for (int n = 0; n < 8; n++) run(n, -1, 0, 1'b0);

    // term changes mid-computation
    run(6, 2, 1, 1'b0);

    // start dropped during CALC
    run(5, -1, 0, 1'b1);

    // randomized runs
    for (int i = 0; i < 10; i++) begin
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)) - 1,
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset mid-CALC
    term  = 3'd7;
    start = 1'b1;
    step();
    step();
    step();
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(oi.valid), 32'd0);
    check("async_rst_result", 32'(oi.result), 32'd0);
`ifdef FIBONACCI_BUSY_EN
    check("async_rst_busy", 32'(busy), 32'd0);
`endif
    last_result = 0;
    step();
    start = 1'b0;
    #2 rst = 1'b1;
    step();
    run(7, -1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
